// File: rtl/seg_to_bcd_capture.sv
// seg_to_bcd_capture: recovers BCD digits from a multiplexed 7-segment bus.
// The segment lines and the one-hot digit select are sampled every cycle. A
// pattern that stays identical for STABLE_CYCLES consecutive samples is
// decoded and committed to the slot of the selected digit. A one-cycle strobe
// reports every commit that changes a slot's stored content.
module seg_to_bcd_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dig_valid,
    output logic [NUM_DIGITS-1:0]   err_flag,
    output logic                    upd_stb,
    output logic [IDX_W-1:0]        upd_idx,
    output logic [3:0]              upd_code
);

    // Decoded glyph: blank marks the all-off pattern, err marks E or unknown.
    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] code;
    } glyph_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    // Segment order is {a,b,c,d,e,f,g} on bits 6..0, active-high.
    function automatic glyph_t decode(input logic [6:0] pat);
        glyph_t g;
        g = '{blank: 1'b0, err: 1'b0, code: 4'h0};
        case (pat)
            7'b1111110: g.code = 4'h0;
            7'b0110000: g.code = 4'h1;
            7'b1101101: g.code = 4'h2;
            7'b1111001: g.code = 4'h3;
            7'b0110011: g.code = 4'h4;
            7'b1011011: g.code = 4'h5;
            7'b1011111: g.code = 4'h6;
            7'b1110010: g.code = 4'h7;
            7'b1111111: g.code = 4'h8;
            7'b1110011: g.code = 4'h9;
            7'b1001111: begin
                g.code = 4'hE;
                g.err  = 1'b1;
            end
            7'b0000000: g.blank = 1'b1;
            default: begin
                g.code = 4'hF;
                g.err  = 1'b1;
            end
        endcase
        return g;
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    // Previous sample of the bus; bit 7 of seg_in carries no information.
    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_sel;
    logic                  unused_seg_msb;

    state_t                state;
    logic [7:0]            run_cnt;

    logic                  same;
    logic                  sample_onehot;
    logic                  run_done;
    glyph_t                dec;
    logic [IDX_W-1:0]      sel_idx;
    logic [3:0]            old_code;
    logic                  old_valid;
    logic                  old_err;
    logic [3:0]            new_code;
    logic                  new_valid;
    logic                  new_err;
    logic                  changed;

    assign unused_seg_msb = seg_in[7];

    // Compare the sample being taken now against the previous one, so that the
    // STABLE_CYCLES-th identical sample commits on the very edge it is taken.
    always_comb begin
        same          = ({seg_in[6:0], dig_sel} == {s_seg, s_sel});
        sample_onehot = is_onehot(dig_sel);
        run_done      = (state == TRACK) && same &&
                        (run_cnt == 8'(STABLE_CYCLES - 1));
    end

    // Slot addressed by the held sample, its current content and its new content.
    always_comb begin
        dec       = decode(s_seg);
        sel_idx   = '0;
        old_code  = '0;
        old_valid = 1'b0;
        old_err   = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s_sel[i]) begin
                sel_idx   = IDX_W'(i);
                old_code  = bcd_out[4*i +: 4];
                old_valid = dig_valid[i];
                old_err   = err_flag[i];
            end
        end
        if (dec.blank) begin
            new_code  = old_code;
            new_valid = 1'b0;
            new_err   = 1'b0;
        end else begin
            new_code  = dec.code;
            new_valid = 1'b1;
            new_err   = dec.err;
        end
        changed = {new_valid, new_err, new_code} != {old_valid, old_err, old_code};
    end

    // Input sampling, stability tracker, slot storage and update strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg     <= '0;
            s_sel     <= '0;
            state     <= IDLE;
            run_cnt   <= '0;
            bcd_out   <= '0;
            dig_valid <= '0;
            err_flag  <= '0;
            upd_stb   <= 1'b0;
            upd_idx   <= '0;
            upd_code  <= '0;
        end else begin
            s_seg   <= seg_in[6:0];
            s_sel   <= dig_sel;
            upd_stb <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_onehot) begin
                        state   <= TRACK;
                        run_cnt <= 8'd1;
                    end else begin
                        run_cnt <= '0;
                    end
                end

                TRACK: begin
                    if (same) begin
                        run_cnt <= run_cnt + 8'd1;
                        if (run_done) begin
                            state <= HOLD;
                            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                if (s_sel[i]) begin
                                    bcd_out[4*i +: 4] <= new_code;
                                    dig_valid[i]      <= new_valid;
                                    err_flag[i]       <= new_err;
                                end
                            end
                            if (changed) begin
                                upd_stb  <= 1'b1;
                                upd_idx  <= sel_idx;
                                upd_code <= new_code;
                            end
                        end
                    end else if (sample_onehot) begin
                        run_cnt <= 8'd1;
                    end else begin
                        state   <= IDLE;
                        run_cnt <= '0;
                    end
                end

                HOLD: begin
                    if (!same) begin
                        if (sample_onehot) begin
                            state   <= TRACK;
                            run_cnt <= 8'd1;
                        end else begin
                            state   <= IDLE;
                            run_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    run_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_to_bcd_capture.sv
// Testbench for seg_to_bcd_capture: directed scenarios followed by random
// segment/select streams, checked against a run-length reference model.
module tb_seg_to_bcd_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] GLYPH [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                          7'h5B, 7'h5F, 7'h72, 7'h7F, 7'h73};

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] code;
    } upd_t;

    logic          clk;
    logic          rst;
    logic [7:0]    seg_in;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] dig_valid;
    logic [ND-1:0] err_flag;
    logic          upd_stb;
    logic [1:0]    upd_idx;
    logic [3:0]    upd_code;

    seg_to_bcd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
        .dig_sel  (dig_sel),
        .bcd_out  (bcd_out),
        .dig_valid(dig_valid),
        .err_flag (err_flag),
        .upd_stb  (upd_stb),
        .upd_idx  (upd_idx),
        .upd_code (upd_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: length of the current run of identical samples
    // since reset, plus the expected content of every slot.
    logic [6:0] prev_seg;
    logic [3:0] prev_sel;
    bit         have_prev;
    int         run_len;
    logic [3:0] m_code  [ND];
    bit         m_valid [ND];
    bit         m_err   [ND];
    logic [1:0] m_idx;
    logic [3:0] m_upd_code;
    upd_t       exp_q [$];

    int  checks;
    int  failures;
    bit  active;
    bit  done;

    function automatic void ref_decode(input logic [6:0] p, output bit blank,
                                       output bit err, output logic [3:0] code);
        blank = 1'b0;
        err   = 1'b1;
        code  = 4'hF;
        if (p == 7'h00) begin
            blank = 1'b1;
            err   = 1'b0;
            code  = 4'h0;
        end else if (p == 7'h4F) begin
            code = 4'hE;
        end else begin
            for (int d = 0; d < 10; d++) begin
                if (GLYPH[d] == p) begin
                    code = 4'(d);
                    err  = 1'b0;
                end
            end
        end
    endfunction

    // Apply what the DUT does on one clock edge to the model.
    task automatic model_edge(input logic [7:0] seg, input logic [3:0] sel, input bit r);
        bit blank, err, nv, ne;
        logic [3:0] code, nc;
        int idx;
        if (r) begin
            have_prev  = 1'b0;
            run_len    = 0;
            m_idx      = '0;
            m_upd_code = '0;
            for (int i = 0; i < ND; i++) begin
                m_code[i]  = '0;
                m_valid[i] = 1'b0;
                m_err[i]   = 1'b0;
            end
        end else begin
            if (have_prev && seg[6:0] == prev_seg && sel == prev_sel) run_len++;
            else run_len = 1;
            prev_seg  = seg[6:0];
            prev_sel  = sel;
            have_prev = 1'b1;
            if (run_len == SC && $countones(sel) == 1) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
                ref_decode(seg[6:0], blank, err, code);
                nv = !blank;
                ne = blank ? 1'b0 : err;
                nc = blank ? m_code[idx] : code;
                if (nv != m_valid[idx] || ne != m_err[idx] || nc != m_code[idx]) begin
                    m_valid[idx] = nv;
                    m_err[idx]   = ne;
                    m_code[idx]  = nc;
                    m_idx        = 2'(idx);
                    m_upd_code   = nc;
                    exp_q.push_back('{idx: 2'(idx), code: nc});
                end
            end
        end
    endtask

    task automatic drive(input logic [7:0] seg, input logic [3:0] sel, input bit r);
        seg_in  = seg;
        dig_sel = sel;
        rst     = r;
        @(posedge clk);
        model_edge(seg, sel, r);
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] seg, input logic [3:0] sel, input int n);
        for (int k = 0; k < n; k++) drive(seg, sel, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares visible outputs against the model and pops the
    // expected update each time the DUT raises its strobe.
    always @(negedge clk) begin
        logic [4*ND-1:0] eb;
        logic [ND-1:0]   ev;
        logic [ND-1:0]   ee;
        upd_t            u;
        if (active) begin
            for (int i = 0; i < ND; i++) begin
                eb[4*i +: 4] = m_code[i];
                ev[i]        = m_valid[i];
                ee[i]        = m_err[i];
            end
            check("bcd_out", 32'(bcd_out), 32'(eb));
            check("dig_valid", 32'(dig_valid), 32'(ev));
            check("err_flag", 32'(err_flag), 32'(ee));
            if (exp_q.size() == 0) begin
                check("upd_stb_idle", 32'(upd_stb), 32'd0);
            end else begin
                u = exp_q.pop_front();
                check("upd_stb", 32'(upd_stb), 32'd1);
                check("upd_idx", 32'(upd_idx), 32'(u.idx));
                check("upd_code", 32'(upd_code), 32'(u.code));
            end
            check("upd_idx_hold", 32'(upd_idx), 32'(m_idx));
            check("upd_code_hold", 32'(upd_code), 32'(m_upd_code));
            if (done) begin
                check("queue_empty", 32'(exp_q.size()), 32'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seg;
        logic [3:0] sel;
        int r;
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        active   = 1'b1;
        seg_in   = '0;
        dig_sel  = '0;
        rst      = 1'b1;

        // Reset, then a first commit of 0 on digit 0.
        drive(8'h00, 4'b0000, 1'b1);
        drive(8'h00, 4'b0000, 1'b1);
        hold(8'h7E, 4'b0001, 4);

        // Scan four digits: 2,3,4,5.
        hold(8'h6D, 4'b0001, 6);
        hold(8'h79, 4'b0010, 6);
        hold(8'h33, 4'b0100, 6);
        hold(8'h5B, 4'b1000, 6);

        // Error glyph, then an unrecognised pattern on digit 2.
        hold(8'h4F, 4'b0100, 4);
        hold(8'h01, 4'b0100, 4);

        // Digit 1 holding 7 with a short glitch in between.
        hold(8'h72, 4'b0010, 5);
        hold(8'h72, 4'b0010, 3);
        hold(8'h7F, 4'b0010, 2);
        hold(8'h72, 4'b0010, 5);

        // Multi-hot select never commits; then a blank on digit 0.
        hold(8'h30, 4'b0011, 10);
        hold(8'h00, 4'b0001, 4);

        // Reset on the third stable sample of a 9 on digit 3, then a fresh run.
        hold(8'h73, 4'b1000, 2);
        drive(8'h73, 4'b1000, 1'b1);
        hold(8'h73, 4'b1000, 6);

        // Bit 7 must not influence decoding.
        hold(8'hB0, 4'b0100, 5);

        // Random streams of held patterns with occasional resets.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10) seg = {1'b0, GLYPH[r]};
            else if (r == 10) seg = 8'h4F;
            else if (r == 11) seg = 8'h00;
            else seg = 8'($urandom);
            seg[7] = 1'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 7) sel = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) sel = 4'b0000;
            else sel = 4'($urandom);
            if ($urandom_range(0, 39) == 0) drive(seg, sel, 1'b1);
            hold(seg, sel, int'($urandom_range(1, 8)));
        end

        hold(8'h00, 4'b0000, 3);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
    end

endmodule
